prio_encoder_hs: RTL and testbench
==================================

Name: prio_encoder_hs

Overview:
- Parametrised, registered N-to-log2(N) priority encoder with a valid/ready output handshake.
- Generalises the 4-to-2 encoder to any N ≥ 2 and adds output holding, a population count and a multiple-request flag.
- An optional round-robin mode is available.
- Sits between request sources (interrupt lines, FIFO-nonempty flags) and a downstream consumer that may stall.

Parameters:
- N, 4, number of request lines; legal range 2..256.
- W, $clog2(N) (localparam, not overridable), index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N  request vector; bit i high = request i active
- out_ready  input  1  consumer accepts the current result
- out_valid  output  1  result registers hold a valid encoding
- out_idx  output  W  index of the winning request
- out_cnt  output  W+1  number of set bits in the sampled req
- out_multi  output  1  more than one bit was set in the sampled req

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_idx=0, out_cnt=0, out_multi=0.
  - FSM goes to EMPTY; rotation pointer ptr=0.
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load condition L = (state==EMPTY) OR (state==FULL AND out_ready).
- On a clock edge with L true:
  - If req≠0: capture out_idx/out_cnt/out_multi from the current req; state→FULL.
  - If req==0: state→EMPTY; out_idx/out_cnt/out_multi keep their old values (don't-care while out_valid=0).
- On a clock edge with L false (FULL, out_ready=0):
  - All outputs hold; req changes are ignored.
  - A request that asserts and deasserts during a stall is lost by design.
- Latency: req sampled at edge k appears on the outputs after edge k. Throughput is one result per cycle while out_ready=1.
- Back-to-back operation: in FULL with out_ready=1 and req≠0, a new result loads in the same cycle (no bubble).
- Fixed priority (macro absent): the highest set index wins. Example: req=4'b0110 → out_idx=2.
- out_cnt: unsigned popcount, width W+1, so all-ones gives out_cnt=N without overflow.
- out_multi = (out_cnt > 1), registered together with the other outputs.
- out_ready while EMPTY has no effect.
- Reset asserted mid-operation: immediate return to reset values regardless of handshake state. The first load is possible on the first edge after rst deasserts.
- Outputs are purely registered; no combinational path from req or out_ready to any output.

Optional Feature:
- Macro: PRIO_ENCODER_RR_EN.
- When defined (round-robin):
  - Search order is ptr-1, ptr-2, …, 0, N-1, …, ptr (indices wrap modulo N).
  - On every load with req≠0, ptr ← winning index. ptr does not change when req==0 or while stalled.
  - ptr resets to 0, so the first search order is N-1..0, identical to fixed priority.
- When not defined:
  - ptr logic is absent and the search order is always fixed (highest index first).
  - Port list is identical in both builds.

Test Plan (N=4):
- Reset then idle: rst pulse, req=0, out_ready=1 for 5 cycles → out_valid=0, out_idx=0, out_cnt=0 throughout.
- Single hot sweep: req=0001, 0010, 0100, 1000 on consecutive cycles, out_ready=1 → out_idx=0,1,2,3 one cycle later each; out_cnt=1, out_multi=0, out_valid continuously 1.
- Priority and count: req=1111 → out_idx=3, out_cnt=4, out_multi=1. Then req=0101 → out_idx=2, out_cnt=2, out_multi=1.
- Stall/hold: load req=0010, then out_ready=0 for 3 cycles while req=1000 → out_idx stays 1 and out_valid stays 1. Raise out_ready → next edge out_idx=3.
- Reset mid-stall: FULL with out_idx=3, out_ready=0, assert rst asynchronously between edges → out_valid=0, out_idx=0, out_cnt=0 immediately, without waiting for a clock edge.
- RR build: req=1111 held, out_ready=1 → out_idx sequence 3,2,1,0,3. Fixed build with the same stimulus → 3,3,3,3,3.

Source files
------------

// File: rtl/prio_encoder_hs.sv
// Registered N-to-log2(N) priority encoder with a valid/ready output handshake.
// Define PRIO_ENCODER_RR_EN to replace fixed highest-index-first priority with round-robin.
module prio_encoder_hs #(
    parameter int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [W:0]   out_cnt,
    output logic         out_multi
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e       state_q, state_d;
    logic         load;
    logic         any_req;
    logic [W-1:0] win_idx;
    logic [W:0]   cnt_sum;
    logic [W-1:0] idx_q;
    logic [W:0]   cnt_q;
    logic         multi_q;

    assign load    = (state_q == StEmpty) || ((state_q == StFull) && out_ready);
    assign any_req = |req;

    // Winner selection
`ifdef PRIO_ENCODER_RR_EN
    logic [W-1:0] ptr_q;
    logic [W:0]   rr_cand;

    // Walk from offset N down to 1 so the candidate nearest below ptr is assigned last and wins.
    always_comb begin
        win_idx = '0;
        rr_cand = '0;
        for (int k = int'(N); k >= 1; k--) begin
            rr_cand = {1'b0, ptr_q} + (W+1)'(int'(N) - k);
            if (rr_cand >= (W+1)'(N)) begin
                rr_cand = rr_cand - (W+1)'(N);
            end
            if (req[rr_cand[W-1:0]]) begin
                win_idx = rr_cand[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (load && any_req) begin
            ptr_q <= win_idx;
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i]) begin
                win_idx = W'(i);
            end
        end
    end
`endif

    always_comb begin
        cnt_sum = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_sum = cnt_sum + (W+1)'(req[i]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = any_req ? StFull : StEmpty;
        end
    end

    // Result registers only update on a load that actually carries a request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            multi_q <= 1'b0;
        end else if (load && any_req) begin
            idx_q   <= win_idx;
            cnt_q   <= cnt_sum;
            multi_q <= (cnt_sum > (W+1)'(1));
        end
    end

    // FSM outputs
    always_comb begin
        out_valid = (state_q == StFull);
        out_idx   = idx_q;
        out_cnt   = cnt_q;
        out_multi = multi_q;
    end

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Table-driven bench for prio_encoder_hs (N=4); expectations follow PRIO_ENCODER_RR_EN when set.
module tb_prio_encoder_hs;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [W:0]   out_cnt;
    logic         out_multi;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic         v;
        logic [W-1:0] idx;
        logic [W:0]   cnt;
        logic         m;
    } vec_t;

    vec_t vecs[$];

    prio_encoder_hs #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_cnt   (out_cnt),
        .out_multi (out_multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic check_all(input string tag, input logic v, input logic [W-1:0] idx,
                             input logic [W:0] cnt, input logic m);
        check({tag, " out_valid"}, int'(out_valid), int'(v));
        check({tag, " out_idx"},   int'(out_idx),   int'(idx));
        check({tag, " out_cnt"},   int'(out_cnt),   int'(cnt));
        check({tag, " out_multi"}, int'(out_multi), int'(m));
    endtask

    // idx_fix / idx_rr: expected winner in the fixed and round-robin builds respectively.
    task automatic add(input logic [N-1:0] r, input logic rdy, input logic v,
                       input logic [W-1:0] idx_fix, input logic [W-1:0] idx_rr,
                       input logic [W:0] cnt, input logic m);
        vec_t t;
        t.req = r;
        t.rdy = rdy;
        t.v   = v;
`ifdef PRIO_ENCODER_RR_EN
        t.idx = idx_rr;
`else
        t.idx = idx_fix;
`endif
        t.cnt = cnt;
        t.m   = m;
        vecs.push_back(t);
    endtask

    logic [W-1:0] rr_exp[5];

    initial begin
        for (int i = 0; i < 5; i++) add(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        add(4'b0001, 1'b1, 1'b1, 2'd0, 2'd0, 3'd1, 1'b0);
        add(4'b0010, 1'b1, 1'b1, 2'd1, 2'd1, 3'd1, 1'b0);
        add(4'b0100, 1'b1, 1'b1, 2'd2, 2'd2, 3'd1, 1'b0);
        add(4'b1000, 1'b1, 1'b1, 2'd3, 2'd3, 3'd1, 1'b0);
        // ptr=3 in RR build: search order 2,1,0,3
        add(4'b1111, 1'b1, 1'b1, 2'd3, 2'd2, 3'd4, 1'b1);
        // ptr=2 in RR build: search order 1,0,3,2
        add(4'b0101, 1'b1, 1'b1, 2'd2, 2'd0, 3'd2, 1'b1);
        add(4'b0010, 1'b1, 1'b1, 2'd1, 2'd1, 3'd1, 1'b0);
        for (int i = 0; i < 3; i++) add(4'b1000, 1'b0, 1'b1, 2'd1, 2'd1, 3'd1, 1'b0);
        add(4'b1000, 1'b1, 1'b1, 2'd3, 2'd3, 3'd1, 1'b0);
        // Empty load keeps old result fields.
        add(4'b0000, 1'b1, 1'b0, 2'd3, 2'd3, 3'd1, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 2'd3, 2'd3, 3'd1, 1'b0);
        // EMPTY loads regardless of out_ready.
        add(4'b0100, 1'b0, 1'b1, 2'd2, 2'd2, 3'd1, 1'b0);
        add(4'b0001, 1'b0, 1'b1, 2'd2, 2'd2, 3'd1, 1'b0);
        add(4'b0001, 1'b1, 1'b1, 2'd0, 2'd0, 3'd1, 1'b0);

`ifdef PRIO_ENCODER_RR_EN
        rr_exp = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
        rr_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif

        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        #2;
        check_all("reset", 1'b0, 2'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].cnt, vecs[i].m);
        end

        // Reset asserted between edges while stalled in FULL.
        @(negedge clk);
        req       = 4'b1000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_all("preload", 1'b1, 2'd3, 3'd1, 1'b0);
        out_ready = 1'b0;
        req       = 4'b0001;
        @(posedge clk);
        #1;
        check_all("stall", 1'b1, 2'd3, 3'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 2'd0, 3'd0, 1'b0);

        // First load right after reset release, then the rotation sequence.
        @(negedge clk);
        rst       = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rot%0d out_idx", i), int'(out_idx), int'(rr_exp[i]));
            check($sformatf("rot%0d out_valid", i), int'(out_valid), 1);
            check($sformatf("rot%0d out_cnt", i), int'(out_cnt), 4);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
